// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the scanned 7-segment receive path.
// Define SEVEN_SEG_DP_EN to carry the active-low decimal point as seg_in bit 7.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_1000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

`ifdef SEVEN_SEG_DP_EN
  localparam int SEG_W = 8;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       error;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{bcd: BCD_BLANK, blank: 1'b1, error: 1'b0, dp: 1'b0};
`else
  localparam int SEG_W = 7;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       error;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{bcd: BCD_BLANK, blank: 1'b1, error: 1'b0};
`endif

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a digit record.
// With SEVEN_SEG_DP_EN the decimal point rides along and never flags an error.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output digit_t           digit_o
);

  always_comb begin
    digit_o       = DIGIT_RESET;
    digit_o.blank = 1'b0;
    case (seg_i[6:0])
      SEG_0:     digit_o.bcd = 4'd0;
      SEG_1:     digit_o.bcd = 4'd1;
      SEG_2:     digit_o.bcd = 4'd2;
      SEG_3:     digit_o.bcd = 4'd3;
      SEG_4:     digit_o.bcd = 4'd4;
      SEG_5:     digit_o.bcd = 4'd5;
      SEG_6:     digit_o.bcd = 4'd6;
      SEG_7:     digit_o.bcd = 4'd7;
      SEG_8:     digit_o.bcd = 4'd8;
      SEG_9:     digit_o.bcd = 4'd9;
      SEG_BLANK: digit_o.blank = 1'b1;
      default:   digit_o.error = 1'b1;
    endcase
`ifdef SEVEN_SEG_DP_EN
    digit_o.dp = ~seg_i[7];
`endif
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Reassembles scanned 7-segment beats into frames and publishes a frame once it
// has repeated STABLE_SCANS times and differs from what is shown. Optional: SEVEN_SEG_DP_EN.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int STABLE_SCANS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [SEG_W-1:0]              seg_in,
  input  logic                          seg_valid,
  input  logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [4*NUM_DIGITS-1:0]       bcd_out,
  output logic [NUM_DIGITS-1:0]         blank_out,
  output logic [NUM_DIGITS-1:0]         error_out,
`ifdef SEVEN_SEG_DP_EN
  output logic [NUM_DIGITS-1:0]         dp_out,
`endif
  output logic                          frame_ready
);

  localparam int               IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       STABLE_MAX = 4'(STABLE_SCANS);

  typedef digit_t [NUM_DIGITS-1:0] frame_t;

  digit_t           beat_digit;
  frame_t           shadow_q, shadow_d;
  frame_t           prev_q, prev_d;
  frame_t           pub_q, pub_d;
  logic [IDX_W-1:0] expected_q, expected_d;
  logic [3:0]       stable_q, stable_d;
  logic             prev_vld_q, prev_vld_d;
  logic             pub_done_q, pub_done_d;
  logic             ready_q, ready_d;

  seg_pattern_decode u_decode (
    .seg_i   (seg_in),
    .digit_o (beat_digit)
  );

  always_comb begin
    shadow_d   = shadow_q;
    prev_d     = prev_q;
    pub_d      = pub_q;
    expected_d = expected_q;
    stable_d   = stable_q;
    prev_vld_d = prev_vld_q;
    pub_done_d = pub_done_q;
    ready_d    = 1'b0;

    if (seg_valid) begin
      if (digit_idx == expected_q) begin
        shadow_d[digit_idx] = beat_digit;
        if (digit_idx == LAST_IDX) begin
          // shadow_d already holds this final beat, so it is the completed frame
          expected_d = '0;
          if (prev_vld_q && (shadow_d == prev_q))
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
          else
            stable_d = 4'd1;
          prev_d     = shadow_d;
          prev_vld_d = 1'b1;
          if ((stable_d == STABLE_MAX) && (!pub_done_q || (shadow_d != pub_q))) begin
            pub_d      = shadow_d;
            pub_done_d = 1'b1;
            ready_d    = 1'b1;
          end
        end else begin
          expected_d = expected_q + 1'b1;
        end
      end else if (digit_idx == '0) begin
        // An out-of-order index 0 restarts the frame with this beat as slot 0
        shadow_d[0] = beat_digit;
        expected_d  = IDX_W'(1);
      end else begin
        expected_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q   <= '0;
      prev_q     <= '0;
      pub_q      <= {NUM_DIGITS{DIGIT_RESET}};
      expected_q <= '0;
      stable_q   <= 4'd0;
      prev_vld_q <= 1'b0;
      pub_done_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      prev_q     <= prev_d;
      pub_q      <= pub_d;
      expected_q <= expected_d;
      stable_q   <= stable_d;
      prev_vld_q <= prev_vld_d;
      pub_done_q <= pub_done_d;
      ready_q    <= ready_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
    assign bcd_out[4*i +: 4] = pub_q[i].bcd;
    assign blank_out[i]      = pub_q[i].blank;
    assign error_out[i]      = pub_q[i].error;
`ifdef SEVEN_SEG_DP_EN
    assign dp_out[i]         = pub_q[i].dp;
`endif
  end

  assign frame_ready = ready_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized bench for seven_seg_scan_decoder against a frame-level reference model.
module tb_seven_seg_scan_decoder;

  localparam int N = 8;
  localparam int S = 2;
`ifdef SEVEN_SEG_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [SW-1:0] seg_in;
  logic          seg_valid;
  logic [2:0]    digit_idx;
  logic [31:0]   bcd_out;
  logic [7:0]    blank_out;
  logic [7:0]    error_out;
  logic          frame_ready;
`ifdef SEVEN_SEG_DP_EN
  logic [7:0]    dp_out;
`endif

  seven_seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_SCANS(S)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .digit_idx   (digit_idx),
    .bcd_out     (bcd_out),
    .blank_out   (blank_out),
    .error_out   (error_out),
`ifdef SEVEN_SEG_DP_EN
    .dp_out      (dp_out),
`endif
    .frame_ready (frame_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: digits kept as integer codes bcd | blank<<4 | error<<5 | dp<<6
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
  int m_exp;
  int m_sh   [N];
  int m_prev [N];
  int m_pub  [N];
  bit m_prev_vld, m_pub_done, m_ready;
  int m_stable;
  int ready_count = 0;

  function automatic int decode_code(input logic [7:0] seg);
    int bcd = 15;
    int blank = 0;
    int err = 0;
    int dp = 0;
    if (seg[6:0] == 7'h7F) blank = 1;
    else begin
      err = 1;
      for (int d = 0; d < 10; d++)
        if (seg[6:0] == seg_tab[d]) begin
          bcd = d;
          err = 0;
        end
    end
`ifdef SEVEN_SEG_DP_EN
    dp = seg[7] ? 0 : 1;
`endif
    return bcd | (blank << 4) | (err << 5) | (dp << 6);
  endfunction

  function automatic bit same_frame(input int a [N], input int b [N]);
    for (int i = 0; i < N; i++) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int idx, input logic [7:0] seg);
    int code;
    m_ready = 1'b0;
    if (rst) begin
      m_exp = 0; m_prev_vld = 0; m_stable = 0; m_pub_done = 0;
      for (int i = 0; i < N; i++) m_pub[i] = 31;
      return;
    end
    if (!v) return;
    code = decode_code(seg);
    if (idx == m_exp) begin
      m_sh[idx] = code;
      if (idx == N - 1) begin
        if (m_prev_vld && same_frame(m_sh, m_prev)) m_stable = (m_stable < S) ? m_stable + 1 : S;
        else m_stable = 1;
        m_prev = m_sh;
        m_prev_vld = 1;
        m_exp = 0;
        if (m_stable == S && (!m_pub_done || !same_frame(m_sh, m_pub))) begin
          m_pub = m_sh;
          m_pub_done = 1;
          m_ready = 1;
        end
      end else m_exp++;
    end else if (idx == 0) begin
      m_sh[0] = code;
      m_exp = 1;
    end else m_exp = 0;
  endtask

  function automatic logic [31:0] exp_bcd();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_pub[i] & 15);
    return r;
  endfunction

  function automatic logic [7:0] exp_bit(input int sh);
    logic [7:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = ((m_pub[i] >> sh) & 1) != 0;
    return r;
  endfunction

  task automatic cycle(input bit rst, input bit v, input int idx, input logic [7:0] seg);
    reset     = rst;
    seg_valid = v;
    digit_idx = idx[2:0];
    seg_in    = seg[SW-1:0];
    @(posedge clock);
    model_step(rst, v, idx, seg);
    if (m_ready) ready_count++;
    #1;
    check_eq("frame_ready", 32'(frame_ready), 32'(m_ready));
    check_eq("bcd_out", bcd_out, exp_bcd());
    check_eq("blank_out", 32'(blank_out), 32'(exp_bit(4)));
    check_eq("error_out", 32'(error_out), 32'(exp_bit(5)));
`ifdef SEVEN_SEG_DP_EN
    check_eq("dp_out", 32'(dp_out), 32'(exp_bit(6)));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, $urandom_range(0, N - 1), 8'($urandom));
  endtask

  function automatic logic [7:0] seg_of(input int d);
    return {1'b1, seg_tab[d]};
  endfunction

  logic [7:0] cur [N];
  logic [7:0] rnd_frames [3][N];

  task automatic scan(input int gaps);
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, gaps));
      cycle(1'b0, 1'b1, i, cur[i]);
    end
  endtask

  task automatic load_ascending();
    for (int i = 0; i < N; i++) cur[i] = seg_of(i);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 0, 8'hFF);
    cycle(1'b1, 1'b0, 0, 8'hFF);
  endtask

  int rc;

  initial begin
    do_reset();
    check_eq("rst_bcd", bcd_out, 32'hFFFF_FFFF);
    check_eq("rst_blank", 32'(blank_out), 32'h0000_00FF);
    check_eq("rst_error", 32'(error_out), 32'h0);
    check_eq("rst_ready", 32'(frame_ready), 32'h0);

    // Two identical ascending frames publish once
    load_ascending();
    rc = ready_count;
    scan(0);
    check_eq("t1_no_ready_frame1", 32'(ready_count - rc), 32'd0);
    scan(0);
    check_eq("t1_ready", 32'(frame_ready), 32'h1);
    check_eq("t1_bcd", bcd_out, 32'h7654_3210);
    check_eq("t1_blank", 32'(blank_out), 32'h0);
    check_eq("t1_error", 32'(error_out), 32'h0);
    idle(1);
    check_eq("t1_pulse_width", 32'(frame_ready), 32'h0);

    // Third identical frame: no re-publication
    rc = ready_count;
    scan(2);
    check_eq("t2_no_republish", 32'(ready_count - rc), 32'd0);
    check_eq("t2_bcd_hold", bcd_out, 32'h7654_3210);

    // Blank digit 3, illegal digit 5
    cur[3] = {1'b1, 7'h7F};
    cur[5] = {1'b1, 7'h7E};
    rc = ready_count;
    scan(1);
    scan(1);
    check_eq("t3_ready_count", 32'(ready_count - rc), 32'd1);
    check_eq("t3_blank", 32'(blank_out), 32'h0000_0008);
    check_eq("t3_error", 32'(error_out), 32'h0000_0020);
    check_eq("t3_bcd", bcd_out, 32'h76F4_F210);

    // Partial frame with a skipped beat is discarded
    do_reset();
    cycle(1'b0, 1'b1, 0, seg_of(0));
    cycle(1'b0, 1'b1, 1, seg_of(1));
    cycle(1'b0, 1'b1, 2, seg_of(2));
    cycle(1'b0, 1'b1, 4, seg_of(4));
    load_ascending();
    rc = ready_count;
    scan(0);
    check_eq("t4_no_ready_frame1", 32'(ready_count - rc), 32'd0);
    check_eq("t4_bcd_reset", bcd_out, 32'hFFFF_FFFF);
    scan(0);
    check_eq("t4_ready", 32'(frame_ready), 32'h1);
    check_eq("t4_bcd", bcd_out, 32'h7654_3210);

    // Alternating frames never stabilise
    do_reset();
    rc = ready_count;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) cur[i] = (k % 2 == 0) ? seg_of(i) : seg_of(N - 1 - i);
      scan(1);
    end
    check_eq("t5_no_ready", 32'(ready_count - rc), 32'd0);
    check_eq("t5_bcd", bcd_out, 32'hFFFF_FFFF);
    check_eq("t5_blank", 32'(blank_out), 32'h0000_00FF);

    // Reset on beat 5 of the second frame
    do_reset();
    load_ascending();
    rc = ready_count;
    scan(0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, i, cur[i]);
    cycle(1'b1, 1'b1, 5, cur[5]);
    cycle(1'b0, 1'b1, 6, cur[6]);
    cycle(1'b0, 1'b1, 7, cur[7]);
    check_eq("t6_no_ready", 32'(ready_count - rc), 32'd0);
    check_eq("t6_bcd_reset", bcd_out, 32'hFFFF_FFFF);
    scan(0);
    scan(0);
    check_eq("t6_ready_count", 32'(ready_count - rc), 32'd1);
    check_eq("t6_bcd", bcd_out, 32'h7654_3210);

    // Randomized frames, glitches, aborts and resets against the model
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        int r = $urandom_range(0, 11);
        logic [7:0] s;
        if (r < 10) s = seg_of(r);
        else if (r == 10) s = 8'hFF;
        else s = 8'($urandom);
        s[7] = 1'($urandom);
        rnd_frames[f][i] = s;
      end
    for (int it = 0; it < 250; it++) begin
      int k = $urandom_range(0, 2);
      int act = $urandom_range(0, 9);
      for (int i = 0; i < N; i++) cur[i] = rnd_frames[k][i];
      if (act == 0) begin
        cycle(1'b1, 1'b0, 0, 8'hFF);
      end else if (act == 1) begin
        int j = $urandom_range(0, N - 2);
        for (int i = 0; i <= j; i++) cycle(1'b0, 1'b1, i, cur[i]);
        cycle(1'b0, 1'b1, $urandom_range(0, N - 1), 8'($urandom));
      end else if (act == 2) begin
        cur[$urandom_range(0, N - 1)] = 8'($urandom);
      end
      repeat ($urandom_range(1, 3)) scan($urandom_range(0, 2));
    end
    check_eq("rand_some_publish", 32'(ready_count > 4), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive side of the display path: takes time-multiplexed, active-low 7-segment patterns, one digit per beat, and decodes them back to BCD.
- Requires STABLE_SCANS consecutive identical frames before publishing, so scan glitches do not reach the outputs.
- Used as a loopback checker and scoreboard source for the display driver, and as a decoder for external scanned displays.

Parameters:
- NUM_DIGITS, 8: digits per frame. Legal range 2..16.
- STABLE_SCANS, 2: consecutive identical complete frames required before publishing. Legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- seg_in  input  7  segment pattern, active-low, bit 6 = g … bit 0 = a.
- seg_valid  input  1  beat qualifier; seg_in and digit_idx are sampled only when high.
- digit_idx  input  $clog2(NUM_DIGITS)  position of this beat's digit; 0 = rightmost.
- bcd_out  output  4*NUM_DIGITS  published digits; digit i at [4i+3:4i].
- blank_out  output  NUM_DIGITS  1 = published digit was all-off.
- error_out  output  NUM_DIGITS  1 = published digit pattern was illegal.
- frame_ready  output  1  one-cycle pulse when the outputs have just updated.

Behaviour:
- Reset (synchronous, active-high) forces:
  - bcd_out all 4'hF; blank_out all 1; error_out all 0; frame_ready 0.
  - Expected index 0; written shadow cleared; stable count 0; previous frame invalid.
- Decode, combinational per beat:
  - 0..9 map to 100_0000, 111_1001, 010_0100, 011_0000, 001_1001, 001_0010, 000_0010, 111_1000, 000_0000, 001_1000.
  - 111_1111 gives bcd 4'hF, blank=1.
  - Any other pattern gives bcd 4'hF, error=1, blank=0.
- Frame assembly:
  - A beat with seg_valid=1 and digit_idx == expected writes the decoded digit into shadow[digit_idx]; expected increments.
  - Out-of-order beat: the frame is aborted and expected resets to 0. If the offending digit_idx is 0, that beat is captured as slot 0 of a new frame (expected becomes 1).
  - seg_valid=0 beats do not advance or abort; gaps of any length are allowed.
- Frame completion happens on the beat with digit_idx == NUM_DIGITS-1 == expected. Same edge:
  - Compare the completed frame (including this beat) to the previous complete frame.
  - Equal and previous valid: stable count increments, saturating at STABLE_SCANS. Otherwise stable count = 1.
  - The completed frame becomes the previous frame; expected returns to 0.
- Publish occurs on the completion edge when both hold:
  - the new stable count == STABLE_SCANS;
  - the frame differs from the currently published outputs, or nothing has been published since reset.
- Publish timing: bcd_out, blank_out and error_out load at the completion edge. frame_ready is registered and high for exactly the one cycle following that edge.
- Re-publication: none for an unchanged frame; a steady display yields a single frame_ready.
- With STABLE_SCANS=1, every complete frame that differs from the published outputs publishes.
- Reset mid-frame discards the partial frame; outputs return to reset values on the next edge.

Optional Feature:
- Macro: SEVEN_SEG_DP_EN.
- Defined:
  - seg_in widens to 8 bits; bit 7 is the decimal point, active-low.
  - Adds output dp_out [NUM_DIGITS-1:0], reset 0, published with the other outputs.
  - The stability compare includes the dp bit.
  - The dp bit never causes an error.
- Undefined: 7-bit seg_in, no dp_out, no dp logic.

Decomposition:
- Package seven_seg_pkg:
  - SEG_0..SEG_9 and SEG_BLANK (7'b111_1111) constants.
  - BCD_BLANK = 4'hF.
  - Typedef digit_t: struct of bcd[3:0], blank, error, plus dp when SEVEN_SEG_DP_EN is defined.
- Sub-module seg_pattern_decode: combinational, seg_in to digit_t, instantiated once in the beat path.
- All state lives in the top module: expected counter, shadow, previous frame, stable counter, published registers.

Test Plan:
- Reset, then scan "01234567" in order twice (STABLE_SCANS=2) -> no frame_ready after frame 1; after frame 2, frame_ready high 1 cycle; bcd_out=32'h7654_3210, blank_out=0, error_out=0.
- Scan "01234567" twice, then a third time -> third frame produces no frame_ready; outputs unchanged.
- Stable frames with digit 3 = 111_1111 and digit 5 = 111_1110 -> blank_out=8'b0000_1000, error_out=8'b0010_0000, nibbles 3 and 5 = 4'hF.
- Beats 0,1,2,4 (skip 3), then two full good frames -> first partial frame discarded; publish after the two full frames only.
- Alternate frames A, B, A, B (each differing) -> no frame_ready; stable count never reaches 2; outputs remain at reset values.
- Assert reset during beat 5 of the second identical frame -> no publish; outputs stay at reset values; two fresh frames then publish normally.
